sobel_ctrl: RTL and testbench

SOBEL_CTRL -- requirements
Module: sobel_ctrl

---
 rtl/sobel_ctrl_if.sv | 32 +++
 rtl/sobel_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sobel_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sobel_ctrl_if.sv
// Pixel-stream, window and control bundle between a raster source and
// sobel_ctrl. The master drives pixels and frame_start; the slave drives the rest.
interface sobel_ctrl_if;
  logic       frame_start;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic [7:0] window00, window01, window02;
  logic [7:0] window10, window11, window12;
  logic [7:0] window20, window21, window22;
  logic       start_conv;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       frame_done;

  modport master (
    output frame_start, pix_valid, pix_data,
    input  pix_ready,
    input  window00, window01, window02, window10, window11, window12,
    input  window20, window21, window22,
    input  start_conv, out_valid, out_last, busy, frame_done
  );

  modport slave (
    input  frame_start, pix_valid, pix_data,
    output pix_ready,
    output window00, window01, window02, window10, window11, window12,
    output window20, window21, window22,
    output start_conv, out_valid, out_last, busy, frame_done
  );
endinterface

// File: rtl/sobel_ctrl.sv
// Raster-scan controller for a 3x3 Sobel window: two line buffers, the
// registered window, and a tag pipeline qualifying the 2-stage datapath output.
module sobel_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  sobel_ctrl_if.slave bus
);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NOUT = (IMG_W - 2) * (IMG_H - 2);
  localparam int OW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [CW-1:0] C_ZERO = CW'(0);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_ZERO = RW'(0);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_TWO  = RW'(2);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [OW-1:0] O_ZERO = OW'(0);
  localparam logic [OW-1:0] O_ONE  = OW'(1);
  localparam logic [OW-1:0] O_LAST = OW'(NOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic          fl_q, fl_d, last_q, last_d, win_real_q, win_real_d;
  logic          t1_q, t1_d, t2_q, t2_d;
  logic          pix_ready_q, pix_ready_d, start_conv_q, start_conv_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          busy_q, busy_d, frame_done_q, frame_done_d;
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];
  logic [7:0]    lb1_q [IMG_W];
  logic [7:0]    lb2_q [IMG_W];
  logic          accept_s, pix_real_s, pix_last_s;

  always_comb begin
    accept_s   = bus.pix_valid && pix_ready_q;
    pix_real_s = (r_q >= R_TWO) && (c_q >= C_TWO);
    pix_last_s = (r_q == R_LAST) && (c_q == C_LAST);
  end

  // Leaving RUN waits one cycle after the last accept so FLUSH drains after that window's own start_conv.
  always_comb begin
    state_d    = state_q;
    fl_d       = 1'b0;
    last_d     = 1'b0;
    c_d        = c_q;
    r_d        = r_q;
    win_real_d = win_real_q;
    case (state_q)
      IDLE: begin
        c_d = C_ZERO;
        r_d = R_ZERO;
        if (bus.frame_start) state_d = RUN;
        else                 state_d = IDLE;
      end
      RUN: begin
        if (last_q) begin
          state_d = FLUSH;
        end else if (accept_s) begin
          last_d     = pix_last_s;
          win_real_d = pix_real_s;
          if (c_q == C_LAST) begin
            c_d = C_ZERO;
            r_d = (r_q == R_LAST) ? R_ZERO : r_q + R_ONE;
          end else begin
            c_d = c_q + C_ONE;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        fl_d = ~fl_q;
        if (fl_q) state_d = DONE;
        else      state_d = FLUSH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_ready_d  = (state_d == RUN) && !last_d;
    start_conv_d = (accept_s && pix_real_s) || (state_d == FLUSH);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
    if (start_conv_q) begin
      t1_d = win_real_q && (state_q != FLUSH);
      t2_d = t1_q;
    end else begin
      t1_d = t1_q;
      t2_d = t2_q;
    end
    out_valid_d = start_conv_q && t2_d;
    if (state_q == IDLE) begin
      out_cnt_d  = O_ZERO;
      out_last_d = 1'b0;
    end else if (out_valid_d) begin
      out_last_d = (out_cnt_q == O_LAST);
      out_cnt_d  = out_last_d ? O_ZERO : out_cnt_q + O_ONE;
    end else begin
      out_cnt_d  = out_cnt_q;
      out_last_d = 1'b0;
    end
  end

  always_comb begin
    if (accept_s) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb2_q[c_q];
      win_d[1][2] = lb1_q[c_q];
      win_d[2][2] = bus.pix_data;
    end else begin
      win_d = win_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      c_q          <= C_ZERO;
      r_q          <= R_ZERO;
      out_cnt_q    <= O_ZERO;
      fl_q         <= 1'b0;
      last_q       <= 1'b0;
      win_real_q   <= 1'b0;
      t1_q         <= 1'b0;
      t2_q         <= 1'b0;
      pix_ready_q  <= 1'b0;
      start_conv_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= 8'd0;
        end
      end
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      r_q          <= r_d;
      out_cnt_q    <= out_cnt_d;
      fl_q         <= fl_d;
      last_q       <= last_d;
      win_real_q   <= win_real_d;
      t1_q         <= t1_d;
      t2_q         <= t2_d;
      pix_ready_q  <= pix_ready_d;
      start_conv_q <= start_conv_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers carry no reset; rows with r<2 never form a real window.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb2_q[c_q] <= lb1_q[c_q];
      lb1_q[c_q] <= bus.pix_data;
    end
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.start_conv = start_conv_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.window00   = win_q[0][0];
  assign bus.window01   = win_q[0][1];
  assign bus.window02   = win_q[0][2];
  assign bus.window10   = win_q[1][0];
  assign bus.window11   = win_q[1][1];
  assign bus.window12   = win_q[1][2];
  assign bus.window20   = win_q[2][0];
  assign bus.window21   = win_q[2][1];
  assign bus.window22   = win_q[2][2];
endmodule

// File: tb/tb_sobel_ctrl.sv
// Directed bench for sobel_ctrl on a 4x4 image with a 2-stage Sobel datapath
// attached; output_word packs {Gx[15:0], Gy[15:0]}.
module tb_sobel_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  sobel_ctrl_if bus();
  sobel_ctrl #(.IMG_W(4), .IMG_H(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [15:0] gx1, gy1;
  logic [31:0] out_word;

  // Datapath: stage 1 forms Gx/Gy from the window, stage 2 publishes the word.
  always @(posedge clk) begin
    if (bus.start_conv) begin
      gx1 <= 16'((int'(bus.window02) + 2 * int'(bus.window12) + int'(bus.window22))
               - (int'(bus.window00) + 2 * int'(bus.window10) + int'(bus.window20)));
      gy1 <= 16'((int'(bus.window20) + 2 * int'(bus.window21) + int'(bus.window22))
               - (int'(bus.window00) + 2 * int'(bus.window01) + int'(bus.window02)));
      out_word <= {gx1, gy1};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    case (mode)
      1:       return 8'(10 * c);
      2:       return 8'(10 * r);
      default: return 8'd10;
    endcase
  endfunction

  task automatic run_frame(input string name, input int mode, input bit gaps, input bit fs_mid,
                           input int abort_at, input logic [31:0] exp_word, output int first_acc);
    int acc, nout, nsc, cyc, last_cyc, done_cyc, last_idx;
    bit acc_now, sc_ok;
    acc = 0; nout = 0; nsc = 0; cyc = 0;
    last_cyc = -1; done_cyc = -1; last_idx = -1; first_acc = -1;
    sc_ok = 1'b1;
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    while (done_cyc < 0 && cyc < 200 && !(abort_at > 0 && acc == abort_at)) begin
      bus.pix_valid   = (acc >= 16) || !gaps || (cyc % 2 == 0);
      bus.pix_data    = (acc < 16) ? pix(mode, acc / 4, acc % 4) : 8'hFF;
      bus.frame_start = fs_mid && (cyc == 5);
      acc_now = bus.pix_valid && bus.pix_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc_now) acc++;
      if (bus.start_conv) begin
        nsc++;
        if (!acc_now && acc < 16) sc_ok = 1'b0;
      end
      if (bus.out_valid) begin
        nout++;
        if (first_acc < 0) first_acc = acc;
        if (bus.out_last) last_idx = nout;
        last_cyc = cyc;
        chk({name, " output_word"}, out_word, exp_word);
      end
      if (bus.frame_done) begin
        done_cyc = cyc;
        chk({name, " pix_ready in DONE"}, 32'(bus.pix_ready), 32'd0);
      end
    end
    bus.frame_start = 1'b0;
    if (abort_at == 0) begin
      chk({name, " out_valid count"}, 32'(nout), 32'd4);
      chk({name, " out_last index"}, 32'(last_idx), 32'd4);
      chk({name, " frame_done cycle"}, 32'(done_cyc), 32'(last_cyc + 1));
      chk({name, " start_conv count"}, 32'(nsc), 32'd6);
      chk({name, " start_conv cause"}, 32'(sc_ok), 32'd1);
      @(posedge clk); #1;
      chk({name, " busy in IDLE"}, 32'(bus.busy), 32'd0);
      chk({name, " pix_ready in IDLE"}, 32'(bus.pix_ready), 32'd0);
      bus.pix_valid = 1'b0;
    end
  endtask

  initial begin
    int fa;
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst pix_ready", 32'(bus.pix_ready), 32'd0);
    chk("rst start_conv", 32'(bus.start_conv), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_last", 32'(bus.out_last), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst window00", 32'(bus.window00), 32'd0);
    chk("rst window22", 32'(bus.window22), 32'd0);

    rst = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'h55;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("idle pix_ready", 32'(bus.pix_ready), 32'd0);
    end
    chk("idle busy", 32'(bus.busy), 32'd0);
    chk("idle window22", 32'(bus.window22), 32'd0);
    bus.pix_valid = 1'b0;

    run_frame("const", 0, 1'b0, 1'b0, 0, 32'h0000_0000, fa);
    chk("const window00", 32'(bus.window00), 32'd10);
    chk("const window22", 32'(bus.window22), 32'd10);

    run_frame("hramp", 1, 1'b0, 1'b0, 0, 32'h0050_0000, fa);
    chk("hramp window00", 32'(bus.window00), 32'd10);
    chk("hramp window02", 32'(bus.window02), 32'd30);
    chk("hramp window20", 32'(bus.window20), 32'd10);
    chk("hramp window22", 32'(bus.window22), 32'd30);

    run_frame("vramp gaps", 2, 1'b1, 1'b0, 0, 32'h0000_0050, fa);
    chk("vramp window02", 32'(bus.window02), 32'd10);
    chk("vramp window20", 32'(bus.window20), 32'd30);

    run_frame("fs in RUN", 0, 1'b0, 1'b1, 0, 32'h0000_0000, fa);

    run_frame("abort", 1, 1'b0, 1'b0, 7, 32'h0050_0000, fa);
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort rst busy", 32'(bus.busy), 32'd0);
    chk("abort rst pix_ready", 32'(bus.pix_ready), 32'd0);
    chk("abort rst start_conv", 32'(bus.start_conv), 32'd0);
    chk("abort rst window22", 32'(bus.window22), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame("after abort", 1, 1'b0, 1'b0, 0, 32'h0050_0000, fa);
    chk("after abort first out_valid", 32'(fa >= 11), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
